sysbus_mem_responder: RTL and testbench
=======================================

Name: sysbus_mem_responder

Overview:
- Memory-side responder for the processor's multiplexed SysBus. The control unit is the initiator and drives ALE, nME, nOE and nWE.
- Captures the address phase on ALE and decodes it against a base window. Serves reads by driving registered data onto SysBus, and commits writes into an internal synchronous RAM.
- Sits between the pad/bus model and the on-chip RAM, replacing the behavioural memory in system testbenches.

Parameters:
- DATA_W, 16: SysBus and memory word width.
- ADDR_W, 10: word-address bits decoded locally; depth = 2**ADDR_W.
- BASE_ADDR, 0: value SysBusIn[DATA_W-1:ADDR_W] must equal for a hit.

Ports:
- Clock  in  1  system clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high reset.
- SysBusIn  in  DATA_W  bus value as seen at the pad (address or write data).
- SysBusOut  out  DATA_W  read data driven toward the bus.
- SysBusOe  out  1  output enable for SysBusOut; pad tri-states when 0.
- ALE  in  1  address latch enable, active high.
- nME  in  1  memory enable, active low.
- nOE  in  1  output enable, active low.
- nWE  in  1  write enable, active low.
- Hit  out  1  registered; latched address is inside this responder's window.
- BusErr  out  1  one-cycle pulse on protocol violation.

Behaviour:
- Interface decided: one clock (Clock); reset is synchronous and active-high (Reset).
- Reset (sampled at posedge):
  - State = IDLE.
  - AddrReg = 0, Hit = 0, SysBusOut = 0, SysBusOe = 0, BusErr = 0.
  - RAM contents are not cleared.
  - Reset mid-transaction aborts it; no partial write occurs at that edge.
- States: IDLE, ADDR, READ, WRITE.
- ALE = 1 at posedge, from any state:
  - AddrReg <= SysBusIn[ADDR_W-1:0].
  - Hit <= (SysBusIn[DATA_W-1:ADDR_W] == BASE_ADDR).
  - State -> ADDR.
  - ALE has highest priority over nME/nOE/nWE in the same cycle.
- ADDR, Hit = 1, nME = 0, nOE = 0, nWE = 1:
  - State -> READ.
  - RAM is read at AddrReg; SysBusOut is valid on the next cycle (1-cycle read latency).
- READ:
  - SysBusOe = (state == READ) & !ALE & !nOE & !nME, combinational. This gating prevents contention during the initiator's address phase.
  - SysBusOut is held stable while in READ.
  - Exit to ADDR when nOE or nME deasserts.
- ADDR, Hit = 1, nME = 0, nWE = 0, nOE = 1:
  - mem[AddrReg] <= SysBusIn at that edge; state -> WRITE.
  - Exactly one commit per WRITE entry; further low-nWE cycles are ignored.
  - Exit to ADDR when nWE or nME rises.
- nOE = 0 and nWE = 0 with nME = 0 and Hit = 1:
  - BusErr = 1 for one cycle.
  - No write and no drive; state -> ADDR.
- Hit = 0: never drives, never writes, never flags BusErr. Hit persists until the next ALE.
- nME high in any non-IDLE state: state -> ADDR; AddrReg is retained for back-to-back accesses.
- Address wrap: only the low ADDR_W bits index the RAM; no wrap logic is needed.

Decomposition:
- Shared package (sysbus_pkg):
  - enum responder_state_t {IDLE, ADDR, READ, WRITE}.
  - Bus width constant.
  - Active-low strobe polarity constants.
- Sub-module sram_sync (parameters DATA_W, ADDR_W):
  - Ports: Clock, We, Addr, Wd, Rd.
  - Single-port, registered read; no reset on the array.

Test Plan:
- Write then read: ALE with 16'h0012 → nME=0, nWE=0, bus=16'hBEEF for 2 cycles; then ALE 16'h0012 → nME=0, nOE=0. Expect SysBusOe=1 and SysBusOut=16'hBEEF one cycle after the read is qualified; exactly one write commit.
- Miss: BASE_ADDR=0, ALE with 16'h0412 → read strobes. Expect Hit=0, SysBusOe=0 throughout; mem[12] unchanged.
- Contention guard: during READ, assert ALE=1 with nOE still 0. Expect SysBusOe=0 in that same cycle; AddrReg takes the new address.
- Protocol error: after ALE 16'h0005, drive nOE=0 and nWE=0 together. Expect BusErr pulses one cycle; mem[5] is unchanged.
- Reset mid-write: ALE 16'h0007, nWE=0, Reset=1 at the same edge. Expect mem[7] retains its old value; state IDLE; all outputs 0 on the next cycle.
- Back-to-back: after a read of address 3, toggle nME high then low with nOE=0 and no new ALE. Expect address 3 is read again with the same data.

Source files
------------

// File: rtl/sysbus_pkg.sv
// Shared SysBus definitions: responder states, bus width and strobe polarity.
package sysbus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } responder_state_t;

  localparam int unsigned SYSBUS_W = 16;

  // nME/nOE/nWE are all active-low on the pad
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  function automatic logic strobe_active(input logic strobe);
    return (strobe == STROBE_ON);
  endfunction

endpackage

// File: rtl/sram_sync.sv
// Single-port synchronous RAM with registered read; the array has no reset.
module sram_sync #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              Clock,
  input  logic              We,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] Wd,
  output logic [DATA_W-1:0] Rd
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // write commit and read-before-write data register
  always_ff @(posedge Clock) begin
    if (We) begin
      mem_q[Addr] <= Wd;
    end
    Rd <= mem_q[Addr];
  end

endmodule

// File: rtl/sysbus_mem_responder.sv
// Memory-side SysBus responder: latches the address on ALE, decodes it against
// a base window, serves reads from the local RAM and commits writes into it.
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int unsigned                 DATA_W    = SYSBUS_W,
  parameter int unsigned                 ADDR_W    = 10,
  parameter logic [DATA_W-ADDR_W-1:0]    BASE_ADDR = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] SysBusIn,
  output logic [DATA_W-1:0] SysBusOut,
  output logic              SysBusOe,
  input  logic              ALE,
  input  logic              nME,
  input  logic              nOE,
  input  logic              nWE,
  output logic              Hit,
  output logic              BusErr
);

  responder_state_t  state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hit_q, hit_d;
  logic              buserr_q, buserr_d;
  logic              mem_we_s;
  logic              ram_we_s;
  logic [DATA_W-1:0] rd_data_s;
  logic              me_s, oe_s, we_s;

  assign me_s = strobe_active(nME);
  assign oe_s = strobe_active(nOE);
  assign we_s = strobe_active(nWE);

  // next-state, address latch and write-commit decode
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    hit_d    = hit_q;
    buserr_d = 1'b0;
    mem_we_s = 1'b0;
    if (ALE) begin
      addr_d  = SysBusIn[ADDR_W-1:0];
      hit_d   = (SysBusIn[DATA_W-1:ADDR_W] == BASE_ADDR);
      state_d = ADDR;
    end else if (state_q != IDLE) begin
      if (!me_s) begin
        state_d = ADDR;
      end else if (hit_q && oe_s && we_s) begin
        buserr_d = 1'b1;
        state_d  = ADDR;
      end else begin
        case (state_q)
          ADDR: begin
            if (hit_q && oe_s) begin
              state_d = READ;
            end else if (hit_q && we_s) begin
              state_d  = WRITE;
              mem_we_s = 1'b1;
            end else begin
              state_d = ADDR;
            end
          end
          READ: begin
            if (!oe_s) begin
              state_d = ADDR;
            end else begin
              state_d = READ;
            end
          end
          // the single commit happened on entry; stay until nWE rises
          WRITE: begin
            if (!we_s) begin
              state_d = ADDR;
            end else begin
              state_d = WRITE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end else begin
      state_d = IDLE;
    end
  end

  // a reset edge must never complete a pending write
  assign ram_we_s = mem_we_s & ~Reset;

  // state, latched address, hit flag and error pulse registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      hit_q    <= 1'b0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      hit_q    <= hit_d;
      buserr_q <= buserr_d;
    end
  end

  sram_sync #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_sram (
    .Clock (Clock),
    .We    (ram_we_s),
    .Addr  (addr_q),
    .Wd    (SysBusIn),
    .Rd    (rd_data_s)
  );

  // ALE gating keeps the pad quiet while the initiator drives an address
  assign SysBusOe  = (state_q == READ) & ~ALE & oe_s & me_s;
  assign SysBusOut = (state_q == READ) ? rd_data_s : '0;
  assign Hit       = hit_q;
  assign BusErr    = buserr_q;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Scoreboard bench for sysbus_mem_responder: stimulus queues expected read data
// and error pulses, a negedge monitor consumes them as the DUT presents outputs.
module tb_sysbus_mem_responder;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] SysBusIn;
  logic [15:0] SysBusOut;
  logic        SysBusOe;
  logic        ALE, nME, nOE, nWE;
  logic        Hit, BusErr;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_q [$];
  int          err_exp = 0;

  always #5 Clock = ~Clock;

  sysbus_mem_responder #(
    .DATA_W    (16),
    .ADDR_W    (10),
    .BASE_ADDR (6'd0)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .SysBusIn  (SysBusIn),
    .SysBusOut (SysBusOut),
    .SysBusOe  (SysBusOe),
    .ALE       (ALE),
    .nME       (nME),
    .nOE       (nOE),
    .nWE       (nWE),
    .Hit       (Hit),
    .BusErr    (BusErr)
  );

  // monitor: read data on every driven cycle, error pulses when they appear
  initial begin
    logic        oe_prev;
    logic        have_exp;
    logic [15:0] cur_exp;
    oe_prev  = 1'b0;
    have_exp = 1'b0;
    cur_exp  = 16'h0000;
    forever begin
      @(negedge Clock);
      if (SysBusOe === 1'b1) begin
        if (!oe_prev) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            have_exp = 1'b0;
            $display("FAIL rd_unexpected: SysBusOut=%h driven, no read expected", SysBusOut);
          end else begin
            cur_exp  = exp_q.pop_front();
            have_exp = 1'b1;
          end
        end
        if (have_exp) begin
          n_cmp++;
          if (SysBusOut !== cur_exp) begin
            n_bad++;
            $display("FAIL rd_data: got %h expected %h", SysBusOut, cur_exp);
          end
        end
      end
      oe_prev = (SysBusOe === 1'b1);
      if (BusErr === 1'b1) begin
        n_cmp++;
        if (err_exp > 0) begin
          err_exp--;
        end else begin
          n_bad++;
          $display("FAIL berr_unexpected: BusErr=1 expected 0");
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    ALE = 1'b0; nME = 1'b1; nOE = 1'b1; nWE = 1'b1;
  endtask

  task automatic alat(input logic [15:0] a);
    idle_bus();
    ALE = 1'b1;
    SysBusIn = a;
    tick();
    ALE = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d0, input logic [15:0] d1);
    alat(a);
    nME = 1'b0; nWE = 1'b0; SysBusIn = d0;
    tick();
    SysBusIn = d1;
    tick();
    idle_bus();
    tick();
  endtask

  task automatic do_read(input logic [15:0] a, input logic [15:0] d, input int ncyc);
    alat(a);
    exp_q.push_back(d);
    nME = 1'b0; nOE = 1'b0;
    repeat (ncyc + 1) tick();
    idle_bus();
    tick();
  endtask

  initial begin
    Reset = 1'b1;
    SysBusIn = 16'h0000;
    idle_bus();
    tick();
    tick();
    Reset = 1'b0;
    chk("rst_hit", {15'd0, Hit}, 16'h0000);
    chk("rst_oe", {15'd0, SysBusOe}, 16'h0000);
    chk("rst_out", SysBusOut, 16'h0000);
    chk("rst_berr", {15'd0, BusErr}, 16'h0000);

    do_write(16'h0012, 16'hBEEF, 16'hBEEF);
    chk("hit_0012", {15'd0, Hit}, 16'h0001);
    do_write(16'h0003, 16'h3C3C, 16'h3C3C);
    do_write(16'h0005, 16'h5A5A, 16'h5A5A);
    do_write(16'h0007, 16'h7777, 16'h7777);
    do_write(16'h0020, 16'hAAAA, 16'h5555);

    // read 0x12, then re-address to 3 mid-read, then nME bounce re-reads 3
    alat(16'h0012);
    exp_q.push_back(16'hBEEF);
    nME = 1'b0; nOE = 1'b0;
    tick();
    tick();
    tick();
    ALE = 1'b1; SysBusIn = 16'h0003;
    #1;
    chk("contention_oe", {15'd0, SysBusOe}, 16'h0000);
    tick();
    ALE = 1'b0;
    exp_q.push_back(16'h3C3C);
    tick();
    tick();
    nME = 1'b1;
    exp_q.push_back(16'h3C3C);
    tick();
    nME = 1'b0;
    tick();
    tick();
    idle_bus();
    tick();

    do_read(16'h0020, 16'hAAAA, 2);

    // window miss: no drive, no write, no error
    alat(16'h0412);
    chk("miss_hit", {15'd0, Hit}, 16'h0000);
    nME = 1'b0; nOE = 1'b0;
    tick();
    chk("miss_oe_rd", {15'd0, SysBusOe}, 16'h0000);
    nOE = 1'b1; nWE = 1'b0; SysBusIn = 16'h0BAD;
    tick();
    nOE = 1'b0;
    tick();
    chk("miss_oe_both", {15'd0, SysBusOe}, 16'h0000);
    idle_bus();
    tick();
    chk("miss_hit_hold", {15'd0, Hit}, 16'h0000);
    do_read(16'h0012, 16'hBEEF, 1);

    // both strobes low on a hit
    alat(16'h0005);
    nME = 1'b0; nOE = 1'b0; nWE = 1'b0; SysBusIn = 16'hFFFF;
    err_exp++;
    tick();
    chk("berr_pulse", {15'd0, BusErr}, 16'h0001);
    chk("berr_oe", {15'd0, SysBusOe}, 16'h0000);
    idle_bus();
    tick();
    chk("berr_clear", {15'd0, BusErr}, 16'h0000);
    do_read(16'h0005, 16'h5A5A, 1);

    // reset at the write-qualifying edge
    alat(16'h0007);
    nME = 1'b0; nWE = 1'b0; SysBusIn = 16'hDEAD; Reset = 1'b1;
    tick();
    Reset = 1'b0;
    idle_bus();
    chk("mrst_hit", {15'd0, Hit}, 16'h0000);
    chk("mrst_oe", {15'd0, SysBusOe}, 16'h0000);
    chk("mrst_out", SysBusOut, 16'h0000);
    chk("mrst_berr", {15'd0, BusErr}, 16'h0000);
    nME = 1'b0; nOE = 1'b0;
    tick();
    tick();
    chk("idle_no_drive", {15'd0, SysBusOe}, 16'h0000);
    idle_bus();
    tick();
    do_read(16'h0007, 16'h7777, 1);

    tick();
    tick();
    chk("reads_consumed", exp_q.size(), 16'd0);
    chk("berr_consumed", err_exp, 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
